// File: rtl/mem_arb_pkg.sv
// Shared types for mem_port_arbiter: FSM state and transaction owner encodings.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_e;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_L = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Memory-side port of mem_port_arbiter: arbiter is master, memory wrapper is slave.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_arb_rr.sv
// Combinational 2-way round-robin pick; on a tie the requester that was not granted last wins.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic   f_req,
  input  logic   l_req,
  input  owner_e last,
  output logic   grant_f,
  output logic   grant_l,
  output logic   any
);

  always_comb begin
    any     = f_req | l_req;
    grant_f = f_req & (~l_req | (last == OWN_L));
    grant_l = l_req & (~f_req | (last == OWN_F));
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, one transaction at a time.
// Optional BUSY timeout abort is compiled in when MEM_ARB_TIMEOUT_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               f_req,
  input  logic [ADDR_W-1:0]  f_addr,
  output logic               f_gnt,
  output logic               f_done,
  input  logic               l_req,
  input  logic               l_we,
  input  logic [ADDR_W-1:0]  l_addr,
  input  logic [DATA_W-1:0]  l_wdata,
  output logic               l_gnt,
  output logic               l_done,
  output logic [DATA_W-1:0]  rdata,
  output logic               err,
  mem_port_arbiter_if.master mem
);

  if (TIMEOUT == 0) begin : g_timeout_chk
    $error("mem_port_arbiter: TIMEOUT must be nonzero");
  end

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_q, last_d;
  logic              f_gnt_q, f_gnt_d, l_gnt_q, l_gnt_d;
  logic              f_done_q, f_done_d, l_done_q, l_done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              grant_f, grant_l, any;
  logic              finish;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  mem_arb_rr u_rr (
    .f_req   (f_req),
    .l_req   (l_req),
    .last    (last_q),
    .grant_f (grant_f),
    .grant_l (grant_l),
    .any     (any)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    f_gnt_d     = 1'b0;
    l_gnt_d     = 1'b0;
    f_done_d    = 1'b0;
    l_done_d    = 1'b0;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    finish      = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (any) begin
          state_d   = BUSY;
          mem_req_d = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
        if (grant_f) begin
          owner_d     = OWN_F;
          last_d      = OWN_F;
          f_gnt_d     = 1'b1;
          mem_addr_d  = f_addr;
          mem_we_d    = 1'b0;
          mem_wdata_d = '0;
        end
        if (grant_l) begin
          owner_d     = OWN_L;
          last_d      = OWN_L;
          l_gnt_d     = 1'b1;
          mem_addr_d  = l_addr;
          mem_we_d    = l_we;
          mem_wdata_d = l_wdata;
        end
      end
      BUSY: begin
        if (mem.mem_ready) begin
          finish = 1'b1;
          if (!mem_we_q) rdata_d = mem.mem_rdata;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        // Counter value TIMEOUT-1 here means this is the TIMEOUT-th idle BUSY cycle.
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          finish  = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
        if (finish) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          f_done_d  = (owner_q == OWN_F);
          l_done_d  = (owner_q == OWN_L);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_F;
      last_q      <= OWN_F;
      f_gnt_q     <= 1'b0;
      l_gnt_q     <= 1'b0;
      f_done_q    <= 1'b0;
      l_done_q    <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      f_gnt_q     <= f_gnt_d;
      l_gnt_q     <= l_gnt_d;
      f_done_q    <= f_done_d;
      l_done_q    <= l_done_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign f_gnt         = f_gnt_q;
  assign l_gnt         = l_gnt_q;
  assign f_done        = f_done_q;
  assign l_done        = l_done_q;
  assign rdata         = rdata_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign err           = err_q;
`else
  assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios followed by two randomized requesters.
module tb_mem_port_arbiter;

  localparam logic [63:0] BASE = 64'h1000;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_req = 1'b0;
  logic [63:0] f_addr = '0;
  logic        f_gnt, f_done;
  logic        l_req = 1'b0, l_we = 1'b0;
  logic [63:0] l_addr = '0, l_wdata = '0;
  logic        l_gnt, l_done;
  logic [63:0] rdata;
  logic        err;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) mif ();

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .f_req   (f_req),
    .f_addr  (f_addr),
    .f_gnt   (f_gnt),
    .f_done  (f_done),
    .l_req   (l_req),
    .l_we    (l_we),
    .l_addr  (l_addr),
    .l_wdata (l_wdata),
    .l_gnt   (l_gnt),
    .l_done  (l_done),
    .rdata   (rdata),
    .err     (err),
    .mem     (mif.master)
  );

  int checks = 0;
  int failures = 0;

  txn_t        fq[$], lq[$];
  txn_t        cur_t;
  logic [63:0] ref_mem [8];
  logic [63:0] mem_arr [8];
  logic [63:0] exp_rdata = '0;
  logic        tb_last = 1'b0;
  logic        cur_own = 1'b0;
  logic        in_txn = 1'b0;
  logic        mon_en = 1'b0;
  logic        auto_mem = 1'b0;
  logic        sf = 1'b0, sl = 1'b0;
  int          cyc = 0, gnt_cyc = 0, waits = 0, wcnt = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return f_gnt;
      1:       return l_gnt;
      2:       return f_done;
      3:       return l_done;
      4:       return f_gnt | l_gnt;
      default: return f_done | l_done;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input int limit, input string name);
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (sig(sel)) return;
    end
    checks++;
    failures++;
    $display("FAIL %s: no pulse within %0d cycles", name, limit);
  endtask

  task automatic idle_gap();
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Requests as seen by the DUT at each rising edge.
  always @(posedge clk) begin
    sf = f_req;
    sl = l_req;
  end

  // Monitor / scoreboard and, in auto mode, the memory responder.
  always @(negedge clk) begin
    txn_t t;
    cyc++;
    if (rst_n && mon_en) begin
      if (f_done || l_done) begin
        check("done_onehot", f_done & l_done, 0);
        check("done_in_txn", in_txn, 1);
        check("done_owner", l_done, cur_own);
        check("done_mem_req", mif.mem_req, 0);
        check("done_err", err, 0);
        if (auto_mem && in_txn) check("done_latency", cyc - gnt_cyc, waits + 1);
        if (l_done ? (lq.size() > 0) : (fq.size() > 0)) begin
          t = l_done ? lq.pop_front() : fq.pop_front();
          if (t.we) ref_mem[t.addr[5:3]] = t.wdata;
          else      exp_rdata = ref_mem[t.addr[5:3]];
        end
        in_txn = 1'b0;
      end
      if (f_gnt || l_gnt) begin
        check("gnt_onehot", f_gnt & l_gnt, 0);
        check("gnt_while_busy", in_txn, 0);
        check("gnt_without_req", l_gnt ? sl : sf, 1);
        if (sf && sl) check("rr_tie", l_gnt, !tb_last);
        check("gnt_mem_req", mif.mem_req, 1);
        tb_last = l_gnt;
        cur_own = l_gnt;
        in_txn  = 1'b1;
        gnt_cyc = cyc;
        wcnt    = 0;
        waits   = $urandom_range(0, 3);
        check("gnt_queue", l_gnt ? (lq.size() > 0) : (fq.size() > 0), 1);
        if (l_gnt ? (lq.size() > 0) : (fq.size() > 0)) begin
          cur_t = l_gnt ? lq[0] : fq[0];
          check("gnt_mem_addr", mif.mem_addr, cur_t.addr);
          check("gnt_mem_we", mif.mem_we, cur_t.we);
          check("gnt_mem_wdata", mif.mem_wdata, cur_t.wdata);
        end
      end
      check("rdata_hold", rdata, exp_rdata);
    end
    if (auto_mem) begin
      if (rst_n && mif.mem_req && in_txn) begin
        if (wcnt >= waits) begin
          check("busy_mem_addr", mif.mem_addr, cur_t.addr);
          mif.mem_ready = 1'b1;
          if (mif.mem_we) mem_arr[mif.mem_addr[5:3]] = mif.mem_wdata;
          mif.mem_rdata = mem_arr[mif.mem_addr[5:3]];
        end else begin
          mif.mem_ready = 1'b0;
          mif.mem_rdata = {$urandom, $urandom};
        end
        wcnt++;
      end else begin
        mif.mem_ready = 1'($urandom_range(0, 1));
        mif.mem_rdata = {$urandom, $urandom};
      end
    end
  end

  task automatic run_f(input int n);
    txn_t t;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      t.we = 1'b0;
      t.addr = BASE + 64'(8 * $urandom_range(0, 7));
      t.wdata = '0;
      fq.push_back(t);
      f_addr = t.addr;
      f_req = 1'b1;
      wait_sig(0, 200, "rand_f_gnt");
      f_addr = {$urandom, $urandom};
      wait_sig(2, 200, "rand_f_done");
      @(posedge clk);
      #1 f_req = 1'b0;
    end
  endtask

  task automatic run_l(input int n);
    txn_t t;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      t.we = 1'($urandom_range(0, 1));
      t.addr = BASE + 64'(8 * $urandom_range(0, 7));
      t.wdata = {$urandom, $urandom};
      lq.push_back(t);
      l_we = t.we;
      l_addr = t.addr;
      l_wdata = t.wdata;
      l_req = 1'b1;
      wait_sig(1, 200, "rand_l_gnt");
      l_addr = {$urandom, $urandom};
      l_wdata = {$urandom, $urandom};
      l_we = ~l_we;
      if ($urandom_range(0, 2) == 0) l_req = 1'b0;
      wait_sig(3, 200, "rand_l_done");
      @(posedge clk);
      #1 l_req = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v;
    for (int i = 0; i < 8; i++) begin
      v = {$urandom, $urandom};
      mem_arr[i] = v;
      ref_mem[i] = v;
    end
    mem_arr[0] = 64'h13;
    ref_mem[0] = 64'h13;
    mif.mem_ready = 1'b0;
    mif.mem_rdata = '0;

    // Both requesters held high from reset: expect L, F, L, F.
    auto_mem = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      fq.push_back('{1'b0, 64'h1000, 64'h0});
      lq.push_back('{1'b0, 64'h1008, 64'h0});
    end
    f_addr = 64'h1000;
    l_addr = 64'h1008;
    f_req = 1'b1;
    l_req = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_mem_req", mif.mem_req, 0);
    check("reset_mem_we", mif.mem_we, 0);
    check("reset_mem_addr", mif.mem_addr, 0);
    check("reset_mem_wdata", mif.mem_wdata, 0);
    check("reset_rdata", rdata, 0);
    check("reset_gnt", {f_gnt, l_gnt}, 0);
    check("reset_done", {f_done, l_done}, 0);
    check("reset_err", err, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_sig(4, 50, "tie_gnt");
      check("tie_order", l_gnt, (k % 2 == 0));
    end
    wait_sig(5, 50, "tie_done");
    @(posedge clk);
    #1 f_req = 1'b0;
    l_req = 1'b0;

    // Zero-wait fetch timing.
    idle_gap();
    auto_mem = 1'b0;
    mif.mem_ready = 1'b1;
    mif.mem_rdata = 64'h13;
    fq.push_back('{1'b0, 64'h1000, 64'h0});
    f_addr = 64'h1000;
    f_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t1_f_gnt", f_gnt, 1);
    check("t1_mem_addr", mif.mem_addr, 64'h1000);
    check("t1_mem_we", mif.mem_we, 0);
    @(negedge clk);
    check("t1_f_done", f_done, 1);
    check("t1_rdata", rdata, 64'h13);
    @(posedge clk);
    #1 f_req = 1'b0;
    mif.mem_ready = 1'b0;

    // Store with 3 wait cycles.
    idle_gap();
    lq.push_back('{1'b1, 64'h2008, 64'hDEADBEEF});
    l_we = 1'b1;
    l_addr = 64'h2008;
    l_wdata = 64'hDEADBEEF;
    l_req = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) check("t2_l_gnt", l_gnt, 1);
      check("t2_mem_we", mif.mem_we, 1);
      check("t2_mem_wdata", mif.mem_wdata, 64'hDEADBEEF);
      check("t2_early_done", l_done, 0);
      if (i == 3) begin
        mif.mem_ready = 1'b1;
        mem_arr[1] = 64'hDEADBEEF;
      end
    end
    @(negedge clk);
    check("t2_l_done", l_done, 1);
    check("t2_rdata_kept", rdata, 64'h13);
    @(posedge clk);
    #1 l_req = 1'b0;
    l_we = 1'b0;
    l_wdata = '0;
    mif.mem_ready = 1'b0;

    // Request dropped and address changed during BUSY.
    idle_gap();
    lq.push_back('{1'b0, 64'h1010, 64'h0});
    l_addr = 64'h1010;
    l_req = 1'b1;
    wait_sig(1, 10, "t4_gnt");
    l_req = 1'b0;
    l_addr = 64'h3000;
    l_we = 1'b1;
    @(negedge clk);
    check("t4_mem_addr", mif.mem_addr, 64'h1010);
    check("t4_mem_we", mif.mem_we, 0);
    mif.mem_ready = 1'b1;
    mif.mem_rdata = mem_arr[2];
    @(negedge clk);
    check("t4_l_done", l_done, 1);
    mif.mem_ready = 1'b0;
    l_we = 1'b0;

    // Asynchronous reset in the second BUSY cycle.
    idle_gap();
    fq.push_back('{1'b0, 64'h1018, 64'h0});
    f_addr = 64'h1018;
    f_req = 1'b1;
    wait_sig(0, 10, "t5_gnt");
    @(negedge clk);
    #1 mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t5_mem_req", mif.mem_req, 0);
    check("t5_mem_we", mif.mem_we, 0);
    check("t5_mem_addr", mif.mem_addr, 0);
    check("t5_mem_wdata", mif.mem_wdata, 0);
    check("t5_rdata", rdata, 0);
    check("t5_pulses", {f_gnt, l_gnt, f_done, l_done, err}, 0);
    fq.delete();
    lq.delete();
    in_txn = 1'b0;
    tb_last = 1'b0;
    exp_rdata = '0;
    f_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fq.push_back('{1'b0, 64'h1000, 64'h0});
    lq.push_back('{1'b0, 64'h1008, 64'h0});
    f_addr = 64'h1000;
    l_addr = 64'h1008;
    f_req = 1'b1;
    l_req = 1'b1;
    auto_mem = 1'b1;
    mon_en = 1'b1;
    wait_sig(4, 10, "t5_tie_gnt");
    check("t5_tie_to_l", l_gnt, 1);
    f_req = 1'b0;
    fq.delete();
    wait_sig(3, 20, "t5_l_done");
    @(posedge clk);
    #1 l_req = 1'b0;

    // Memory never ready: abort with the timeout build, wait forever without it.
    idle_gap();
    auto_mem = 1'b0;
    mif.mem_ready = 1'b0;
    mon_en = 1'b0;
    f_addr = 64'h1020;
    f_req = 1'b1;
    wait_sig(0, 10, "t6_gnt");
`ifdef MEM_ARB_TIMEOUT_EN
    check("t6_mem_req_1", mif.mem_req, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_mem_req_held", mif.mem_req, 1);
    end
    @(negedge clk);
    check("t6_f_done", f_done, 1);
    check("t6_err", err, 1);
    check("t6_rdata", rdata, 0);
    check("t6_mem_req_drop", mif.mem_req, 0);
    exp_rdata = '0;
`else
    repeat (20) begin
      @(negedge clk);
      check("t6_mem_req_held", mif.mem_req, 1);
      check("t6_err", err, 0);
      check("t6_no_done", f_done, 0);
    end
    mif.mem_ready = 1'b1;
    mif.mem_rdata = mem_arr[4];
    @(negedge clk);
    check("t6_f_done", f_done, 1);
    check("t6_rdata", rdata, ref_mem[4]);
    exp_rdata = ref_mem[4];
`endif
    @(posedge clk);
    #1 f_req = 1'b0;
    mif.mem_ready = 1'b0;
    tb_last = 1'b0;
    mon_en = 1'b1;

    // Randomized concurrent traffic.
    idle_gap();
    auto_mem = 1'b1;
    fork
      run_f(60);
      run_l(60);
    join
    repeat (5) @(negedge clk);
    check("end_fq_empty", fq.size(), 0);
    check("end_lq_empty", lq.size(), 0);
    check("end_idle", in_txn, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
